// File: rtl/alu_seq_w.sv
// Handshaked WIDTH-bit ALU. Logic ops, add/sub and compares complete in one cycle.
// Shifts and the shift-add multiply iterate one step per BUSY cycle.
module alu_seq_w #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carryout,
   output logic             overflow,
   output logic             illegal
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b1011;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           op_q, op_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [SHW:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 zero_q, zero_d;
   logic                 carry_q, carry_d;
   logic                 ovf_q, ovf_d;
   logic                 ill_q, ill_d;

   logic                 accept;
   logic [SHW-1:0]       k;
   logic [WIDTH:0]       add_w;
   logic [WIDTH:0]       sub_w;
   logic                 slt_bit;
   logic [WIDTH-1:0]     sc_result;
   logic                 sc_carry;
   logic                 sc_ovf;
   logic                 sc_ill;
   logic                 start_iter;
   logic [WIDTH-1:0]     sh_val;
   logic [WIDTH-1:0]     sh_next;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH-1:0]     fin_result;
   logic                 fin_ovf;

   assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign carryout  = carry_q;
   assign overflow  = ovf_q;
   assign illegal   = ill_q;

   assign k       = b[SHW-1:0];
   assign add_w   = {1'b0, a} + {1'b0, b};
   assign sub_w   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign slt_bit = ($signed(a) < $signed(b));

   // Single-cycle datapath; shifts with k=0 simply pass a through.
   always_comb begin
      sc_result  = '0;
      sc_carry   = 1'b0;
      sc_ovf     = 1'b0;
      sc_ill     = 1'b0;
      start_iter = 1'b0;
      case (ALUctrl)
         OP_AND: sc_result = a & b;
         OP_OR:  sc_result = a | b;
         OP_XOR: sc_result = a ^ b;
         OP_NOR: sc_result = ~(a | b);
         OP_ADD: begin
            sc_result = add_w[WIDTH-1:0];
            sc_carry  = add_w[WIDTH];
            sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_result = sub_w[WIDTH-1:0];
            sc_carry  = sub_w[WIDTH];
            sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_SLL, OP_SRL, OP_SRA: begin
            sc_result  = a;
            start_iter = (k != '0);
         end
         OP_MUL: start_iter = 1'b1;
         default: sc_ill = 1'b1;
      endcase
   end

   assign sh_val = acc_q[WIDTH-1:0];

   always_comb begin
      case (op_q)
         OP_SLL:  sh_next = {sh_val[WIDTH-2:0], 1'b0};
         OP_SRL:  sh_next = {1'b0, sh_val[WIDTH-1:1]};
         default: sh_next = {sh_val[WIDTH-1], sh_val[WIDTH-1:1]};
      endcase
   end

   // Multiplicand walks left while the multiplier walks right, one partial product per step.
   assign mul_next   = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
   assign fin_result = (op_q == OP_MUL) ? mul_next[WIDTH-1:0] : sh_next;
   assign fin_ovf    = (op_q == OP_MUL) ? (|mul_next[2*WIDTH-1:WIDTH]) : 1'b0;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      ill_d    = ill_q;
      case (state_q)
         S_BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (op_q == OP_MUL) begin
               acc_d    = mul_next;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
            end else begin
               acc_d = {{WIDTH{1'b0}}, sh_next};
            end
            if (cnt_q == {{SHW{1'b0}}, 1'b1}) begin
               state_d  = S_DONE;
               result_d = fin_result;
               zero_d   = (fin_result == '0);
               carry_d  = 1'b0;
               ovf_d    = fin_ovf;
               ill_d    = 1'b0;
            end
         end
         default: begin
            if (accept) begin
               op_d = ALUctrl;
               if (start_iter) begin
                  state_d  = S_BUSY;
                  cnt_d    = (ALUctrl == OP_MUL) ? (SHW+1)'(WIDTH) : {1'b0, k};
                  acc_d    = (ALUctrl == OP_MUL) ? {(2*WIDTH){1'b0}} : {{WIDTH{1'b0}}, a};
                  mcand_d  = {{WIDTH{1'b0}}, a};
                  mplier_d = b;
               end else begin
                  state_d  = S_DONE;
                  result_d = sc_result;
                  zero_d   = (sc_result == '0);
                  carry_d  = sc_carry;
                  ovf_d    = sc_ovf;
                  ill_d    = sc_ill;
               end
            end else if (state_q == S_DONE && out_ready) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         ill_q    <= ill_d;
      end
   end

endmodule

// File: tb/tb_alu_seq_w.sv
// Directed bench for alu_seq_w at WIDTH=8 with hand-computed results, latencies and flags.
module tb_alu_seq_w;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] ALUctrl;
   logic [7:0] a, b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       zero, carryout, overflow, illegal;

   int checks = 0;
   int errors = 0;

   alu_seq_w #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ALUctrl(ALUctrl), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .carryout(carryout), .overflow(overflow),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] ctrl, input logic [7:0] av, input logic [7:0] bv);
      int guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk_eq("ready_wait", 32'(guard < 50), 32'd1);
      ALUctrl  = ctrl;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat, output int stall);
      lat   = 0;
      stall = 0;
      while (!out_valid && lat < 40) begin
         if (!in_ready) stall++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run(input string tag, input logic [3:0] ctrl, input logic [7:0] av,
                      input logic [7:0] bv, input int lat_e, input logic [7:0] res_e,
                      input logic c_e, input logic o_e, input logic z_e, input logic i_e);
      int lat, stall;
      send(ctrl, av, bv);
      wait_out(lat, stall);
      chk_eq({tag, "_lat"},   32'(lat), 32'(lat_e));
      chk_eq({tag, "_stall"}, 32'(stall), 32'(lat_e));
      chk_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk_eq({tag, "_res"},   32'(result), 32'(res_e));
      chk_eq({tag, "_carry"}, 32'(carryout), 32'(c_e));
      chk_eq({tag, "_ovf"},   32'(overflow), 32'(o_e));
      chk_eq({tag, "_zero"},  32'(zero), 32'(z_e));
      chk_eq({tag, "_ill"},   32'(illegal), 32'(i_e));
      $display("%-8s ctrl=%b a=%02h b=%02h -> res=%02h c=%0b v=%0b z=%0b ill=%0b lat=%0d",
               tag, ctrl, av, bv, result, carryout, overflow, zero, illegal, lat);
   endtask

   initial begin
      int lat, stall, seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      ALUctrl = 4'b0000; a = 8'h00; b = 8'h00;
      #1;
      chk_eq("rst_valid", 32'(out_valid), 32'd0);
      chk_eq("rst_ready", 32'(in_ready), 32'd1);
      chk_eq("rst_res",   32'(result), 32'd0);
      chk_eq("rst_flags", {28'd0, zero, carryout, overflow, illegal}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run("ADD",    4'b0010, 8'd200, 8'd100, 0, 8'd44,  1'b1, 1'b0, 1'b0, 1'b0);
      run("ADDOV",  4'b0010, 8'h7F,  8'h01,  0, 8'h80,  1'b0, 1'b1, 1'b0, 1'b0);
      run("SUBBR",  4'b0110, 8'd3,   8'd5,   0, 8'hFE,  1'b0, 1'b0, 1'b0, 1'b0);
      run("AND",    4'b0000, 8'hCC,  8'hAA,  0, 8'h88,  1'b0, 1'b0, 1'b0, 1'b0);
      run("OR",     4'b0001, 8'hCC,  8'hAA,  0, 8'hEE,  1'b0, 1'b0, 1'b0, 1'b0);
      run("XOR",    4'b0011, 8'hCC,  8'hAA,  0, 8'h66,  1'b0, 1'b0, 1'b0, 1'b0);
      run("NOR",    4'b1100, 8'hF0,  8'h0F,  0, 8'h00,  1'b0, 1'b0, 1'b1, 1'b0);
      run("SLT1",   4'b0111, 8'hFF,  8'h01,  0, 8'h01,  1'b0, 1'b0, 1'b0, 1'b0);
      run("SLT0",   4'b0111, 8'h01,  8'hFF,  0, 8'h00,  1'b0, 1'b0, 1'b1, 1'b0);
      run("SRA3",   4'b1010, 8'h90,  8'd3,   3, 8'hF2,  1'b0, 1'b0, 1'b0, 1'b0);
      run("SRA0",   4'b1010, 8'h90,  8'd0,   0, 8'h90,  1'b0, 1'b0, 1'b0, 1'b0);
      run("SRL4",   4'b1001, 8'h90,  8'd4,   4, 8'h09,  1'b0, 1'b0, 1'b0, 1'b0);
      run("SLL2",   4'b1000, 8'h81,  8'h0A,  2, 8'h04,  1'b0, 1'b0, 1'b0, 1'b0);
      run("MULOV",  4'b1011, 8'd16,  8'd17,  8, 8'h10,  1'b0, 1'b1, 1'b0, 1'b0);
      run("MUL",    4'b1011, 8'd7,   8'd9,   8, 8'd63,  1'b0, 1'b0, 1'b0, 1'b0);
      run("ILL",    4'b1111, 8'd3,   8'd4,   0, 8'h00,  1'b0, 1'b0, 1'b1, 1'b1);

      // DONE -> IDLE when taken with no new request
      @(posedge clk); #1;
      chk_eq("idle_valid", 32'(out_valid), 32'd0);
      chk_eq("idle_ready", 32'(in_ready), 32'd1);

      // back-to-back single-cycle ops
      ALUctrl = 4'b0110; a = 8'd5; b = 8'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      chk_eq("b2b1_valid", 32'(out_valid), 32'd1);
      chk_eq("b2b1_res",   32'(result), 32'd0);
      chk_eq("b2b1_zc",    {30'd0, zero, carryout}, 32'd3);
      chk_eq("b2b1_ready", 32'(in_ready), 32'd1);
      $display("SUB      a=05 b=05 -> res=%02h z=%0b c=%0b", result, zero, carryout);
      a = 8'h80; b = 8'h01;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_eq("b2b2_valid", 32'(out_valid), 32'd1);
      chk_eq("b2b2_res",   32'(result), 32'h7F);
      chk_eq("b2b2_flags", {29'd0, overflow, carryout, zero}, 32'b110);
      $display("SUB      a=80 b=01 -> res=%02h v=%0b c=%0b z=%0b", result, overflow, carryout, zero);
      @(posedge clk); #1;

      // consumer stalls for 5 cycles while a competing request is presented
      out_ready = 1'b0;
      send(4'b0010, 8'h7F, 8'h01);
      wait_out(lat, stall);
      for (int i = 0; i < 5; i++) begin
         ALUctrl = 4'b0000; a = 8'h00; b = 8'h00; in_valid = 1'b1;
         chk_eq("hold_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         chk_eq("hold_valid", 32'(out_valid), 32'd1);
         chk_eq("hold_res",   32'(result), 32'h80);
         chk_eq("hold_flags", {28'd0, zero, carryout, overflow, illegal}, 32'b0010);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      $display("HOLD     5 stalled cycles res=%02h v=%0b", result, overflow);
      @(posedge clk); #1;
      chk_eq("hold_release", 32'(out_valid), 32'd0);

      // reset in the middle of a multiply
      send(4'b1011, 8'd16, 8'd17);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk_eq("abort_valid", 32'(out_valid), 32'd0);
      chk_eq("abort_res",   32'(result), 32'd0);
      chk_eq("abort_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk_eq("abort_silent", 32'(seen), 32'd0);
      $display("ABORT    MUL reset mid-flight, outputs seen after release=%0d", seen);
      run("ADDRST", 4'b0010, 8'd1, 8'd1, 0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
